seven_seg_scan_capture: RTL and testbench

//  Display-side reader for the multiplexed four-digit 7-segment bus (an3..an0, a..g, dp).

---
 rtl/seven_seg_scan_capture.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_seven_seg_scan_capture.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_capture.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_capture
//
// Reader for a multiplexed four-digit 7-segment bus. It watches the scanned
// anode and segment lines, decodes each steady pattern back to a hex nibble,
// and emits one complete four-digit frame per scan. It can be used as a
// monitor in benches or as an on-chip loopback checker for a display driver.
//
// Ports
//   clk             in   1   system clock, rising edge
//   reset           in   1   synchronous, active-high
//   i_an3..i_an0    in   1   anode enables, active-low (an3 = leftmost digit)
//   i_a..i_g        in   1   segment lines, active-low
//   i_dp            in   1   decimal point, active-low
//   o_frame         out  16  captured digits {d3,d2,d1,d0}
//   o_dp_mask       out  4   captured decimal point per digit, 1 = lit
//   o_blank_mask    out  4   1 = that digit had every segment off
//   o_frame_valid   out  1   one-cycle pulse when the frame outputs update
//   o_frame_changed out  1   pulses with o_frame_valid when the frame differs
//                            from the previously emitted one
//   o_seg_err       out  1   sticky: undecodable segment pattern seen
//   o_an_err        out  1   sticky: stable anode vector neither one-hot-low
//                            nor all-high
//   o_scan_timeout  out  1   one-cycle pulse when a partial frame is aborted
// ---------------------------------------------------------------------------
module seven_seg_scan_capture #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_an3,
    input  logic        i_an2,
    input  logic        i_an1,
    input  logic        i_an0,
    input  logic        i_a,
    input  logic        i_b,
    input  logic        i_c,
    input  logic        i_d,
    input  logic        i_e,
    input  logic        i_f,
    input  logic        i_g,
    input  logic        i_dp,
    output logic [15:0] o_frame,
    output logic [3:0]  o_dp_mask,
    output logic [3:0]  o_blank_mask,
    output logic        o_frame_valid,
    output logic        o_frame_changed,
    output logic        o_seg_err,
    output logic        o_an_err,
    output logic        o_scan_timeout
);

    // One extra bit on the stability counter guarantees its saturation value
    // lies above the hit value, so the hit is seen exactly once per dwell.
    localparam int STAB_W = $clog2(SETTLE_CYCLES) + 1;
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [STAB_W-1:0] STAB_HIT = STAB_W'(SETTLE_CYCLES - 1);
    localparam logic [STAB_W-1:0] STAB_MAX = '1;
    localparam logic [TO_W-1:0]   TO_HIT   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_MAX   = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_EMIT
    } state_t;

    // -----------------------------------------------------------------------
    // Input registers and one-cycle delayed copy for the stability compare
    // -----------------------------------------------------------------------
    logic [3:0]        r_an;
    logic [3:0]        r_an_d;
    logic [6:0]        r_seg;
    logic [6:0]        r_seg_d;
    logic              r_dp;
    logic              r_dp_d;
    logic [STAB_W-1:0] r_stab;

    logic w_same;
    assign w_same = ({r_an, r_seg, r_dp} == {r_an_d, r_seg_d, r_dp_d});

    always_ff @(posedge clk) begin
        if (reset) begin
            r_an    <= 4'hF;
            r_an_d  <= 4'hF;
            r_seg   <= 7'h7F;
            r_seg_d <= 7'h7F;
            r_dp    <= 1'b1;
            r_dp_d  <= 1'b1;
            r_stab  <= '0;
        end else begin
            r_an    <= {i_an3, i_an2, i_an1, i_an0};
            r_seg   <= {i_a, i_b, i_c, i_d, i_e, i_f, i_g};
            r_dp    <= i_dp;
            r_an_d  <= r_an;
            r_seg_d <= r_seg;
            r_dp_d  <= r_dp;
            if (!w_same) begin
                r_stab <= '0;
            end else if (r_stab != STAB_MAX) begin
                r_stab <= r_stab + 1'b1;
            end
        end
    end

    // When the counter shows the hit value, the delayed copy has held the
    // same value for SETTLE_CYCLES registered cycles; that copy is sampled.
    logic w_sample;
    assign w_sample = (r_stab == STAB_HIT);

    // -----------------------------------------------------------------------
    // Anode classification
    // -----------------------------------------------------------------------
    logic [3:0] w_an_lit;
    logic       w_onehot;
    logic       w_gap;
    logic       w_slot_valid;
    logic       w_an_bad;

    assign w_an_lit     = ~r_an_d;
    assign w_onehot     = (w_an_lit != 4'h0) && ((w_an_lit & (w_an_lit - 1'b1)) == 4'h0);
    assign w_gap        = (r_an_d == 4'hF);
    assign w_slot_valid = w_sample && w_onehot;
    assign w_an_bad     = w_sample && !w_onehot && !w_gap;

    // -----------------------------------------------------------------------
    // Segment decode; bit order of w_lit is {a,b,c,d,e,f,g}, 1 = lit
    // -----------------------------------------------------------------------
    logic [6:0] w_lit;
    logic [3:0] w_nib;
    logic       w_blank;
    logic       w_illegal;
    logic       w_dp_lit;

    assign w_lit    = ~r_seg_d;
    assign w_dp_lit = ~r_dp_d;

    always_comb begin
        w_nib     = 4'h0;
        w_blank   = 1'b0;
        w_illegal = 1'b0;
        case (w_lit)
            7'h7E: w_nib = 4'h0;
            7'h30: w_nib = 4'h1;
            7'h6D: w_nib = 4'h2;
            7'h79: w_nib = 4'h3;
            7'h33: w_nib = 4'h4;
            7'h5B: w_nib = 4'h5;
            7'h5F: w_nib = 4'h6;
            7'h70: w_nib = 4'h7;
            7'h7F: w_nib = 4'h8;
            7'h7B: w_nib = 4'h9;
            7'h77: w_nib = 4'hA;
            7'h1F: w_nib = 4'hB;
            7'h4E: w_nib = 4'hC;
            7'h3D: w_nib = 4'hD;
            7'h4F: w_nib = 4'hE;
            7'h47: w_nib = 4'hF;
            7'h00: w_blank = 1'b1;
            default: w_illegal = 1'b1;
        endcase
    end

    logic w_seg_bad;
    assign w_seg_bad = w_slot_valid && w_illegal;

    // -----------------------------------------------------------------------
    // FSM state, capture mask and timeout counter
    // -----------------------------------------------------------------------
    state_t          r_state;
    logic [3:0]      r_mask;
    logic [TO_W-1:0] r_to_cnt;

    logic       w_to_hit;
    logic       w_take;
    logic [3:0] w_mask_next;

    assign w_to_hit    = (r_state == S_COLLECT) && (r_to_cnt == TO_HIT);
    // A sample landing on the abort cycle belongs to a discarded frame.
    assign w_take      = w_slot_valid && !w_to_hit;
    assign w_mask_next = r_mask | w_an_lit;

    // -----------------------------------------------------------------------
    // Shadow registers holding the frame under construction
    // -----------------------------------------------------------------------
    logic [3:0] r_sh_nib [4];
    logic [3:0] r_sh_dp;
    logic [3:0] r_sh_blank;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                r_sh_nib[k] <= 4'h0;
            end
            r_sh_dp    <= 4'h0;
            r_sh_blank <= 4'h0;
        end else if (w_take) begin
            for (int k = 0; k < 4; k++) begin
                if (w_an_lit[k]) begin
                    r_sh_nib[k]   <= w_nib;
                    r_sh_dp[k]    <= w_dp_lit;
                    r_sh_blank[k] <= w_blank;
                end
            end
        end
    end

    logic [15:0] w_sh_frame;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pack
            assign w_sh_frame[gi*4 +: 4] = r_sh_nib[gi];
        end
    endgenerate

    logic w_differs;
    assign w_differs = ({w_sh_frame, r_sh_dp, r_sh_blank} != {o_frame, o_dp_mask, o_blank_mask});

    // Set once a frame has been emitted since reset, so the first frame after
    // reset always reports a change even if it happens to match zero outputs.
    logic r_prev_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_mask          <= 4'h0;
            r_to_cnt        <= '0;
            r_prev_valid    <= 1'b0;
            o_frame         <= 16'h0;
            o_dp_mask       <= 4'h0;
            o_blank_mask    <= 4'h0;
            o_frame_valid   <= 1'b0;
            o_frame_changed <= 1'b0;
            o_seg_err       <= 1'b0;
            o_an_err        <= 1'b0;
            o_scan_timeout  <= 1'b0;
        end else begin
            o_frame_valid   <= 1'b0;
            o_frame_changed <= 1'b0;
            o_scan_timeout  <= 1'b0;

            if (w_seg_bad) begin
                o_seg_err <= 1'b1;
            end
            if (w_an_bad) begin
                o_an_err <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_slot_valid) begin
                        r_mask   <= w_an_lit;
                        r_to_cnt <= '0;
                        r_state  <= S_COLLECT;
                    end
                end

                S_COLLECT: begin
                    if (w_to_hit) begin
                        o_scan_timeout <= 1'b1;
                        r_mask         <= 4'h0;
                        r_state        <= S_IDLE;
                    end else begin
                        if (r_to_cnt != TO_MAX) begin
                            r_to_cnt <= r_to_cnt + 1'b1;
                        end
                        if (w_slot_valid) begin
                            r_mask <= w_mask_next;
                            if (w_mask_next == 4'hF) begin
                                r_state <= S_EMIT;
                            end
                        end
                    end
                end

                S_EMIT: begin
                    o_frame         <= w_sh_frame;
                    o_dp_mask       <= r_sh_dp;
                    o_blank_mask    <= r_sh_blank;
                    o_frame_valid   <= 1'b1;
                    o_frame_changed <= !r_prev_valid || w_differs;
                    r_prev_valid    <= 1'b1;
                    // A sample on this cycle opens the next frame immediately.
                    if (w_slot_valid) begin
                        r_mask   <= w_an_lit;
                        r_to_cnt <= '0;
                        r_state  <= S_COLLECT;
                    end else begin
                        r_mask  <= 4'h0;
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_mask  <= 4'h0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_capture.sv
module tb_seven_seg_scan_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic        an3, an2, an1, an0;
    logic        a, b, c, d, e, f, g;
    logic        dp;
    logic [15:0] o_frame;
    logic [3:0]  o_dp_mask;
    logic [3:0]  o_blank_mask;
    logic        o_frame_valid;
    logic        o_frame_changed;
    logic        o_seg_err;
    logic        o_an_err;
    logic        o_scan_timeout;

    int checks = 0;
    int errors = 0;

    // Pulse bookkeeping from a negedge monitor
    int   fv_cnt = 0;
    int   to_cnt = 0;
    int   orphan_chg = 0;
    logic cap_changed = 1'b0;

    int fv_before;
    int to_before;

    always #5 clk = ~clk;

    seven_seg_scan_capture #(
        .SETTLE_CYCLES (4),
        .TIMEOUT_CYCLES(4096)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_an3          (an3),
        .i_an2          (an2),
        .i_an1          (an1),
        .i_an0          (an0),
        .i_a            (a),
        .i_b            (b),
        .i_c            (c),
        .i_d            (d),
        .i_e            (e),
        .i_f            (f),
        .i_g            (g),
        .i_dp           (dp),
        .o_frame        (o_frame),
        .o_dp_mask      (o_dp_mask),
        .o_blank_mask   (o_blank_mask),
        .o_frame_valid  (o_frame_valid),
        .o_frame_changed(o_frame_changed),
        .o_seg_err      (o_seg_err),
        .o_an_err       (o_an_err),
        .o_scan_timeout (o_scan_timeout)
    );

    always @(negedge clk) begin
        if (o_frame_valid) begin
            fv_cnt      <= fv_cnt + 1;
            cap_changed <= o_frame_changed;
            $display("frame_valid: frame=%h dp=%b blank=%b changed=%b",
                     o_frame, o_dp_mask, o_blank_mask, o_frame_changed);
        end
        if (o_frame_changed && !o_frame_valid) begin
            orphan_chg <= orphan_chg + 1;
        end
        if (o_scan_timeout) begin
            to_cnt <= to_cnt + 1;
            $display("scan_timeout pulse");
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Lit-segment encoding {a,b,c,d,e,f,g} of each hex digit, from the glyph list
    function automatic logic [6:0] seg_of(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;
            4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    // Drive one bus state (lit = 1) for a number of cycles, changing on negedge
    task automatic drive(input logic [3:0] an_lit, input logic [6:0] seg_lit,
                         input logic dp_lit, input int cycles);
        {an3, an2, an1, an0}   = ~an_lit;
        {a, b, c, d, e, f, g}  = ~seg_lit;
        dp                     = ~dp_lit;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic gap(input int cycles);
        drive(4'h0, 7'h00, 1'b0, cycles);
    endtask

    // Scan all four digits, 64 cycles each; rev=1 goes an0 -> an3
    task automatic scan4(input logic [15:0] digits, input logic [3:0] dps, input logic rev);
        int slot;
        for (int k = 0; k < 4; k++) begin
            slot = rev ? k : 3 - k;
            drive(4'(1 << slot), seg_of(digits[slot*4 +: 4]), dps[slot], 64);
        end
    endtask

    initial begin
        reset = 1'b1;
        {an3, an2, an1, an0}  = 4'hF;
        {a, b, c, d, e, f, g} = 7'h7F;
        dp = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_frame", 32'(o_frame), 32'h0);
        chk("rst_flags", 32'({o_dp_mask, o_blank_mask, o_frame_valid, o_frame_changed,
                              o_seg_err, o_an_err, o_scan_timeout}), 32'h0);
        reset = 1'b0;
        gap(10);

        // 1: "1234" scanned an3 -> an0, then repeated
        scan4(16'h1234, 4'h0, 1'b0);
        gap(4);
        chk("t1_fv_count", 32'(fv_cnt), 32'd1);
        chk("t1_frame", 32'(o_frame), 32'h1234);
        chk("t1_dp_blank", 32'({o_dp_mask, o_blank_mask}), 32'h00);
        chk("t1_changed_first", 32'(cap_changed), 32'd1);
        scan4(16'h1234, 4'h0, 1'b0);
        gap(4);
        chk("t1_fv_count2", 32'(fv_cnt), 32'd2);
        chk("t1_changed_repeat", 32'(cap_changed), 32'd0);

        // 2: "AbCd", dp on digit 1, reversed scan order
        scan4(16'hABCD, 4'b0010, 1'b1);
        gap(4);
        chk("t2_fv_count", 32'(fv_cnt), 32'd3);
        chk("t2_frame", 32'(o_frame), 32'hABCD);
        chk("t2_dp_mask", 32'(o_dp_mask), 32'b0010);
        chk("t2_changed", 32'(cap_changed), 32'd1);

        // 3: two-cycle glitch to '8' inside the an2 dwell must not be sampled
        drive(4'b1000, seg_of(4'h1), 1'b0, 64);
        drive(4'b0100, seg_of(4'h2), 1'b0, 20);
        drive(4'b0100, seg_of(4'h8), 1'b0, 2);
        drive(4'b0100, seg_of(4'h2), 1'b0, 42);
        drive(4'b0010, seg_of(4'h3), 1'b0, 64);
        drive(4'b0001, seg_of(4'h4), 1'b0, 64);
        gap(4);
        chk("t3_fv_count", 32'(fv_cnt), 32'd4);
        chk("t3_frame", 32'(o_frame), 32'h1234);
        chk("t3_seg_err", 32'(o_seg_err), 32'd0);

        // 4: only a,g lit on an2 -> nibble 0, seg_err sticky, frame still emitted
        drive(4'b1000, seg_of(4'h1), 1'b0, 64);
        drive(4'b0100, 7'b1000001, 1'b0, 64);
        drive(4'b0010, seg_of(4'h3), 1'b0, 64);
        drive(4'b0001, seg_of(4'h4), 1'b0, 64);
        gap(4);
        chk("t4_fv_count", 32'(fv_cnt), 32'd5);
        chk("t4_frame", 32'(o_frame), 32'h1034);
        chk("t4_blank", 32'(o_blank_mask), 32'h0);
        chk("t4_seg_err", 32'(o_seg_err), 32'd1);
        // Blank digit on an2: nibble 0 with blank bit, seg_err stays set
        drive(4'b1000, seg_of(4'h1), 1'b0, 64);
        drive(4'b0100, 7'h00, 1'b0, 64);
        drive(4'b0010, seg_of(4'h3), 1'b0, 64);
        drive(4'b0001, seg_of(4'h4), 1'b0, 64);
        gap(4);
        chk("t4_blank_frame", 32'(o_frame), 32'h1034);
        chk("t4_blank_mask", 32'(o_blank_mask), 32'b0100);
        chk("t4_blank_changed", 32'(cap_changed), 32'd1);
        chk("t4_seg_err_sticky", 32'(o_seg_err), 32'd1);

        // 5: illegal anode vector, then an incomplete scan until timeout
        reset = 1'b1;
        gap(3);
        reset = 1'b0;
        gap(10);
        chk("t5_seg_err_cleared", 32'(o_seg_err), 32'd0);
        fv_before = fv_cnt;
        to_before = to_cnt;
        drive(4'b1100, seg_of(4'h5), 1'b0, 10);
        gap(4);
        chk("t5_an_err", 32'(o_an_err), 32'd1);
        for (int r = 0; r < 30; r++) begin
            if (to_cnt != to_before) break;
            drive(4'b1000, seg_of(4'h1), 1'b0, 64);
            drive(4'b0100, seg_of(4'h2), 1'b0, 64);
            drive(4'b0010, seg_of(4'h3), 1'b0, 64);
        end
        gap(4);
        chk("t5_timeout_count", 32'(to_cnt), 32'(to_before + 1));
        chk("t5_no_frame", 32'(fv_cnt), 32'(fv_before));
        chk("t5_frame_kept", 32'(o_frame), 32'h0);
        chk("t5_an_err_sticky", 32'(o_an_err), 32'd1);

        // 6: reset after three slots captured, then a full "5678" scan
        drive(4'b1000, seg_of(4'h5), 1'b0, 64);
        drive(4'b0100, seg_of(4'h6), 1'b0, 64);
        drive(4'b0010, seg_of(4'h7), 1'b0, 64);
        reset = 1'b1;
        gap(3);
        chk("t6_rst_frame", 32'(o_frame), 32'h0);
        chk("t6_rst_flags", 32'({o_dp_mask, o_blank_mask, o_frame_valid, o_frame_changed,
                                 o_seg_err, o_an_err, o_scan_timeout}), 32'h0);
        reset = 1'b0;
        gap(10);
        fv_before = fv_cnt;
        scan4(16'h5678, 4'h0, 1'b0);
        gap(4);
        chk("t6_fv_count", 32'(fv_cnt), 32'(fv_before + 1));
        chk("t6_frame", 32'(o_frame), 32'h5678);
        chk("t6_changed", 32'(cap_changed), 32'd1);
        chk("orphan_changed", 32'(orphan_chg), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
